// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: pipeline request/response and byte-RAM signals of the memory controller
interface mem_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  if_req_i;
  logic [ADDR_WIDTH-1:0] if_addr_i;
  logic [31:0]           if_data_o;
  logic                  if_done_o;
  logic                  mem_req_i;
  logic                  mem_we_i;
  logic [1:0]            mem_len_i;
  logic [ADDR_WIDTH-1:0] mem_addr_i;
  logic [31:0]           mem_wdata_i;
  logic [31:0]           mem_rdata_o;
  logic                  mem_done_o;
  logic [7:0]            ram_din_i;
  logic [7:0]            ram_dout_o;
  logic [ADDR_WIDTH-1:0] ram_a_o;
  logic                  ram_wr_o;
  modport master (
    output if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_len_i, mem_addr_i, mem_wdata_i, ram_din_i,
    input  if_data_o, if_done_o, mem_rdata_o, mem_done_o, ram_dout_o, ram_a_o, ram_wr_o
  );
  modport slave (
    input  if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_len_i, mem_addr_i, mem_wdata_i, ram_din_i,
    output if_data_o, if_done_o, mem_rdata_o, mem_done_o, ram_dout_o, ram_a_o, ram_wr_o
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM sequencer arbitrating fetch reads and MEM-stage loads/stores
module mem_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  input logic       rdy,
  mem_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, FIN} state_t;
  state_t state, state_d;
  logic own_mem, wr_q, acc, acc_we, busy;
  logic [2:0] n, k, len_n;
  logic [1:0] kb;
  logic [ADDR_WIDTH-1:0] addr, acc_addr;
  logic [31:0] wdata, asm_q, asm_d;
  assign acc = bus.mem_req_i | bus.if_req_i;
  assign acc_we = bus.mem_req_i & bus.mem_we_i;
  assign acc_addr = bus.mem_req_i ? bus.mem_addr_i : bus.if_addr_i;
  assign len_n = (!bus.mem_req_i || bus.mem_len_i[1]) ? 3'd4 : bus.mem_len_i[0] ? 3'd2 : 3'd1;
  assign kb = k[1:0] - 2'd1;
  assign busy = state == READ || state == WRITE;
  assign bus.ram_wr_o = wr_q & rdy;
  always_comb begin
    asm_d = asm_q;
    asm_d[{kb, 3'b000} +: 8] = bus.ram_din_i;
  end
  // the done cycle keeps the busy state (k = n+1), so FIN is the extra dead cycle after it
  always_comb begin
    state_d = state;
    state_d = state == IDLE ? (acc ? (acc_we ? WRITE : READ) : IDLE)
            : state == FIN ? IDLE : (k > n ? FIN : state);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      own_mem <= 1'b0;
      wr_q <= 1'b0;
      n <= '0;
      k <= '0;
      addr <= '0;
      wdata <= '0;
      asm_q <= '0;
      bus.if_data_o <= '0;
      bus.if_done_o <= 1'b0;
      bus.mem_rdata_o <= '0;
      bus.mem_done_o <= 1'b0;
      bus.ram_dout_o <= '0;
      bus.ram_a_o <= '0;
    end else if (rdy) begin
      state <= state_d;
      bus.if_done_o <= 1'b0;
      bus.mem_done_o <= 1'b0;
      if (state == IDLE && acc) begin
        own_mem <= bus.mem_req_i;
        addr <= acc_addr;
        n <= len_n;
        wdata <= bus.mem_wdata_i;
        asm_q <= '0;
        k <= 3'd1;
        wr_q <= acc_we;
        bus.ram_a_o <= acc_addr;
        if (acc_we) bus.ram_dout_o <= bus.mem_wdata_i[7:0];
      end else if (busy && k < n) begin
        k <= k + 3'd1;
        bus.ram_a_o <= addr + ADDR_WIDTH'(k);
        if (state == READ) asm_q <= asm_d;
        else bus.ram_dout_o <= wdata[{k[1:0], 3'b000} +: 8];
      end else if (busy && k == n) begin
        k <= k + 3'd1;
        wr_q <= 1'b0;
        bus.ram_a_o <= '0;
        if (state == READ && own_mem) bus.mem_rdata_o <= asm_d;
        if (state == READ && !own_mem) bus.if_data_o <= asm_d;
        if (own_mem) bus.mem_done_o <= 1'b1;
        else bus.if_done_o <= 1'b1;
      end else if (state == FIN) k <= '0;
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: randomized scoreboard bench for mem_ctrl against a byte-array reference memory
module tb_mem_ctrl;
  logic clk = 0, rst = 0, rdy = 1;
  mem_ctrl_if #(.ADDR_WIDTH(32)) bus();
  mem_ctrl #(.ADDR_WIDTH(32)) dut(.clk(clk), .rst(rst), .rdy(rdy), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {bit mem; logic [31:0] data; int cyc;} exp_t;
  typedef struct {int cyc; logic [31:0] a; logic [7:0] d;} wr_t;
  exp_t exp_q[$];
  exp_t mon_e;
  wr_t wlog[$];
  bit [7:0] env_ram [bit [31:0]];
  bit [7:0] ref_mem [bit [31:0]];
  int cyc = 0, free_at = 0, n_chk = 0, n_pass = 0, c0;
  logic [31:0] last_if = 0, last_mem = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
  endtask

  function automatic logic [7:0] env_rd(input bit [31:0] a);
    return env_ram.exists(a) ? env_ram[a] : 8'h00;
  endfunction

  function automatic logic [31:0] ref_rd(input bit [31:0] a, input int n);
    logic [31:0] v = 0;
    for (int i = 0; i < n; i++) begin
      bit [31:0] b = a + 32'(i);
      if (ref_mem.exists(b)) v = v | (32'(ref_mem[b]) << (8 * i));
    end
    return v;
  endfunction

  function automatic logic [106:0] outs();
    return {bus.if_data_o, bus.if_done_o, bus.mem_rdata_o, bus.mem_done_o, bus.ram_dout_o, bus.ram_a_o, bus.ram_wr_o};
  endfunction

  // environment RAM: writes land on the clock edge, read data follows the address presented in the cycle
  always @(posedge clk) begin
    if (bus.ram_wr_o) begin
      env_ram[bus.ram_a_o] = bus.ram_dout_o;
      wlog.push_back('{cyc, bus.ram_a_o, bus.ram_dout_o});
    end
    cyc++;
  end
  always @(negedge clk) bus.ram_din_i = env_rd(bus.ram_a_o);

  always @(negedge clk)
    if (!rst && (bus.if_done_o || bus.mem_done_o)) begin
      chk("done overlap", bus.if_done_o & bus.mem_done_o, 0);
      if (exp_q.size() == 0) chk("spurious done", 0, 1);
      else begin
        mon_e = exp_q.pop_front();
        chk("done client", bus.mem_done_o, mon_e.mem);
        chk(mon_e.mem ? "mem data" : "if data", mon_e.mem ? bus.mem_rdata_o : bus.if_data_o, mon_e.data);
        chk("done cycle", cyc, mon_e.cyc);
      end
    end

  task automatic settle();
    while (cyc < free_at) @(negedge clk);
  endtask

  // controller is free two cycles after a done; IF queued behind MEM starts once MEM is free
  task automatic run(input bit do_if, input logic [31:0] ia, input bit do_mem, input bit we,
                     input logic [1:0] len, input logic [31:0] ma, input logic [31:0] wd,
                     input int stall, input bit churn);
    int start, n, m_acc, i_acc, m_done, i_done;
    bit mp, ip;
    start = cyc > free_at ? cyc : free_at;
    m_acc = start; m_done = start; i_acc = start; i_done = start;
    if (do_mem) begin
      n = len[1] ? 4 : len[0] ? 2 : 1;
      m_done = start + n + 1 + stall;
      if (we) for (int i = 0; i < n; i++) ref_mem[ma + 32'(i)] = wd[8*i +: 8];
      else last_mem = ref_rd(ma, n);
      exp_q.push_back('{1'b1, last_mem, m_done});
      i_acc = m_done + 2;
    end
    if (do_if) begin
      i_done = i_acc + 5 + (do_mem ? 0 : stall);
      last_if = ref_rd(ia, 4);
      exp_q.push_back('{1'b0, last_if, i_done});
    end
    free_at = (i_done > m_done ? i_done : m_done) + 2;
    bus.if_addr_i = ia;
    bus.mem_we_i = we;
    bus.mem_len_i = len;
    bus.mem_addr_i = ma;
    bus.mem_wdata_i = wd;
    bus.if_req_i = do_if;
    bus.mem_req_i = do_mem;
    mp = do_mem;
    ip = do_if;
    for (int t = 0; t < 60 && (mp || ip); t++) begin
      @(negedge clk);
      if (bus.mem_done_o) begin mp = 0; bus.mem_req_i = 0; end
      if (bus.if_done_o) begin ip = 0; bus.if_req_i = 0; end
      if (churn && mp && cyc > m_acc) begin
        bus.mem_addr_i = $urandom;
        bus.mem_wdata_i = $urandom;
        bus.mem_len_i = 2'($urandom_range(3));
        bus.mem_we_i = 1'($urandom_range(1));
        if ($urandom_range(3) == 0) bus.mem_req_i = 0;
      end
      if (churn && ip && cyc > i_acc) begin
        bus.if_addr_i = $urandom;
        if ($urandom_range(3) == 0) bus.if_req_i = 0;
      end
    end
    if (mp || ip) begin
      chk("done timeout", {mp, ip}, 0);
      exp_q.delete();
      bus.mem_req_i = 0;
      bus.if_req_i = 0;
    end
  endtask

  task automatic chk_wlog(input string nm, input int base, input logic [31:0] a, input logic [31:0] d,
                          input int o0, input int o1, input int o2, input int o3);
    int offs[4] = '{o0, o1, o2, o3};
    chk({nm, " count"}, wlog.size(), 4);
    for (int i = 0; i < 4 && i < wlog.size(); i++)
      chk(nm, {wlog[i].cyc - base, wlog[i].a, wlog[i].d}, {offs[i], a + 32'(i), d[8*i +: 8]});
  endtask

  initial begin
    bus.if_req_i = 0; bus.if_addr_i = 0; bus.mem_req_i = 0; bus.mem_we_i = 0;
    bus.mem_len_i = 0; bus.mem_addr_i = 0; bus.mem_wdata_i = 0; bus.ram_din_i = 0;
    for (int i = 0; i < 4; i++) begin
      env_ram[32'h100 + 32'(i)] = 8'(8'h11 * (i + 1));
      ref_mem[32'h100 + 32'(i)] = 8'(8'h11 * (i + 1));
    end
    #1 rst = 1;
    #1 chk("reset outputs", outs(), 0);
    repeat (2) @(negedge clk);
    rst = 0;
    free_at = cyc;

    wlog.delete();
    run(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    chk("if read write strobes", wlog.size(), 0);

    settle(); c0 = cyc; wlog.delete();
    run(0, 0, 1, 1, 2'd2, 32'h200, 32'hDEADBEEF, 0, 0);
    chk_wlog("word write", c0, 32'h200, 32'hDEADBEEF, 1, 2, 3, 4);

    settle();
    run(0, 0, 1, 0, 2'd0, 32'h203, 0, 0, 0);

    settle();
    run(1, 32'h100, 1, 1, 2'd1, 32'h300, 32'h00001234, 0, 0);
    settle();
    run(0, 0, 1, 0, 2'd1, 32'h300, 0, 0, 0);

    settle(); c0 = cyc;
    bus.if_addr_i = 32'h100;
    bus.if_req_i = 1;
    repeat (2) @(negedge clk);
    #2 rst = 1;
    #1 chk("async reset", outs(), 0);
    bus.if_req_i = 0;
    last_if = 0;
    last_mem = 0;
    @(negedge clk);
    rst = 0;
    free_at = cyc;
    run(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);

    settle(); c0 = cyc; wlog.delete();
    fork
      run(0, 0, 1, 1, 2'd2, 32'h400, 32'hCAFEF00D, 3, 0);
      begin
        repeat (2) @(negedge clk);
        rdy = 0;
        repeat (3) begin
          #1 chk("stall ram_wr", bus.ram_wr_o, 0);
          @(negedge clk);
        end
        rdy = 1;
      end
    join
    chk_wlog("stalled write", c0, 32'h400, 32'hCAFEF00D, 1, 5, 6, 7);

    settle();
    run(0, 0, 1, 1, 2'd3, 32'hFFFFFFFE, 32'h89ABCDEF, 0, 0);
    settle();
    run(1, 32'hFFFFFFFE, 0, 0, 0, 0, 0, 0, 0);

    for (int it = 0; it < 60; it++) begin
      int kind;
      logic [31:0] a1, a2;
      kind = $urandom_range(2);
      a1 = ($urandom_range(3) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(3)) : 32'h100 + 32'($urandom_range(15));
      a2 = 32'h100 + 32'($urandom_range(15));
      repeat ($urandom_range(2)) @(negedge clk);
      run(kind != 1, a2, kind != 0, 1'($urandom_range(1)), 2'($urandom_range(3)), a1, $urandom, 0, 1);
    end

    settle();
    repeat (3) @(negedge clk);
    chk("leftover expectations", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
Byte-serial memory controller between the pipeline and the single-port, 8-bit-wide main RAM. It accepts word, halfword and byte transactions from instruction fetch (read only) and from the MEM stage (read/write), arbitrates between them, and sequences the individual RAM byte accesses. It returns assembled little-endian read data, zero-extended; sign extension remains in the MEM stage.

Parameters:
ADDR_WIDTH, 32, width of all address ports.

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-high
rdy  input  1  global ready; low freezes the block
if_req_i  input  1  fetch read request, level, held until if_done_o
if_addr_i  input  ADDR_WIDTH  fetch address, stable while requested
if_data_o  output  32  fetched word
if_done_o  output  1  one-cycle completion pulse for fetch
mem_req_i  input  1  MEM-stage request, level, held until mem_done_o
mem_we_i  input  1  1 = write, 0 = read
mem_len_i  input  2  0 = 1 byte, 1 = 2 bytes, 2 or 3 = 4 bytes
mem_addr_i  input  ADDR_WIDTH  MEM-stage address
mem_wdata_i  input  32  store data; low bytes used first
mem_rdata_o  output  32  load data, zero-extended
mem_done_o  output  1  one-cycle completion pulse for MEM stage
ram_din_i  input  8  RAM read byte, valid one cycle after its address
ram_dout_o  output  8  RAM write byte
ram_a_o  output  ADDR_WIDTH  RAM byte address
ram_wr_o  output  1  RAM write strobe

Behaviour:
- All outputs registered except ram_wr_o, which is the registered strobe ANDed with rdy.
- Reset (async): state IDLE, all outputs 0, byte counter 0, latched addr/data 0. Reset during a write may leave a partially written word; this is acceptable.
- rdy low: no register updates. State, counter, outputs and assembled data hold, and ram_wr_o = 0. The RAM is frozen by the same rdy.
- States: IDLE, READ, WRITE, FIN.
- IDLE:
  - If mem_req_i is high, serve MEM. If only if_req_i is high, serve IF. MEM has priority when both are high.
  - On accept: latch owner, address, length n (1/2/4), write data and direction. Drive ram_a_o = addr. Set k = 1.
  - Read accept: ram_wr_o = 0, next state READ.
  - Write accept: ram_dout_o = byte0, ram_wr_o = 1, next state WRITE.
- READ, each edge with counter k:
  - store ram_din_i into byte k-1 of the assembly register;
  - if k < n: ram_a_o = addr + k, k = k + 1;
  - else: copy the assembly register (upper bytes 0) to the owner's data output, pulse the owner's done, ram_a_o = 0, go to FIN.
- WRITE, each edge:
  - if k < n: ram_a_o = addr + k, ram_dout_o = byte k, k = k + 1;
  - else: ram_wr_o = 0, ram_a_o = 0, pulse done, go to FIN.
- FIN: one dead cycle. All requests are ignored so that clients can drop their request after seeing done. Then go to IDLE.
- Latency, with request sampled in cycle 0: done is high in cycle n+1 for both reads and writes. The next transaction can be accepted in cycle n+3.
- Address arithmetic is modulo 2^ADDR_WIDTH; wrap past all-ones is legal.
- if_done_o and mem_done_o are never high in the same cycle.
- Data outputs hold their last value until the same client's next completion.
- Requests are sampled only in IDLE. Changing address, length or data mid-transaction has no effect, because they are latched at accept.
- A request dropped mid-transaction is still completed, and its done still pulses.
- IF is never preempted. A MEM request arriving during an IF transaction waits until the next IDLE.

Test Plan:
- RAM 0x100..0x103 = 11 22 33 44; IF read 0x100 -> if_done_o in cycle 5, if_data_o = 0x44332211, ram_wr_o never high.
- MEM write, len 2, 0xDEADBEEF to 0x200 -> ram_wr_o high cycles 1–4 with bytes EF, BE, AD, DE at 0x200..0x203; mem_done_o in cycle 5.
- MEM read, len 0, from 0x203 after the above -> mem_rdata_o = 0x000000DE, mem_done_o in cycle 2.
- IF read and MEM halfword write 0x1234 to 0x300 requested in the same cycle -> mem_done_o in cycle 3, FIN in cycle 4, IF accepted cycle 5, if_done_o in cycle 10; done pulses never overlap.
- rst pulsed mid-word-read (cycle 2) -> all outputs 0 immediately without a clock edge; after release, a new IF read to 0x100 returns 0x44332211 with normal latency.
- rdy low for cycles 2–4 of a word write -> ram_wr_o = 0 during the stall, all four bytes still written correctly, mem_done_o delayed to cycle 8.
